// File: rtl/tft_pkg.sv
// Shared types and defaults for the TFT 8080-style parallel write bus.
package tft_pkg;

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_IDLE,
    S_WR_LOW,
    S_WR_HIGH
  } tft_wr_state_t;

  localparam int unsigned TFT_WR_LOW_CYC_DEF     = 2;
  localparam int unsigned TFT_WR_HIGH_CYC_DEF    = 2;
  localparam int unsigned TFT_RESET_LOW_CYC_DEF  = 50000;
  localparam int unsigned TFT_RESET_WAIT_CYC_DEF = 6000000;

  localparam int unsigned TFT_W         = 320;
  localparam int unsigned TFT_H         = 240;
  localparam int unsigned TFT_PIX_CNT_W = 17;

  function automatic int unsigned tft_max4(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/tft_bus_writer.sv
// Panel reset sequencer and 8080 write-strobe generator fed by a valid/ready word stream.
// Optional TFT_PIXEL_REPEAT_EN adds in_repeat: each accepted word is written in_repeat times.
module tft_bus_writer
  import tft_pkg::*;
#(
  parameter int unsigned WR_LOW_CYC     = TFT_WR_LOW_CYC_DEF,
  parameter int unsigned WR_HIGH_CYC    = TFT_WR_HIGH_CYC_DEF,
  parameter int unsigned RESET_LOW_CYC  = TFT_RESET_LOW_CYC_DEF,
  parameter int unsigned RESET_WAIT_CYC = TFT_RESET_WAIT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_is_cmd,
  input  logic [15:0]              in_data,
`ifdef TFT_PIXEL_REPEAT_EN
  input  logic [TFT_PIX_CNT_W-1:0] in_repeat,
`endif
  output logic                     init_done,
  output logic                     busy,
  output logic [15:0]              tft_db,
  output logic                     tft_rs,
  output logic                     tft_wr,
  output logic                     tft_rd,
  output logic                     tft_cs,
  output logic                     tft_reset
);

  localparam int unsigned CNT_MAX =
    tft_max4(WR_LOW_CYC, WR_HIGH_CYC, RESET_LOW_CYC, RESET_WAIT_CYC);
  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t WR_LOW_LD     = cnt_t'(WR_LOW_CYC - 1);
  localparam cnt_t WR_HIGH_LD    = cnt_t'(WR_HIGH_CYC - 1);
  localparam cnt_t RESET_LOW_LD  = cnt_t'(RESET_LOW_CYC - 1);
  localparam cnt_t RESET_WAIT_LD = cnt_t'(RESET_WAIT_CYC - 1);

  tft_wr_state_t state_q, state_d;
  cnt_t          cnt_q, cnt_d;
  logic          init_q, init_d;
  logic [15:0]   db_q, db_d;
  logic          rs_q, rs_d;
  logic          wr_q, wr_d;
  logic          cs_q, cs_d;
  logic          rstn_q, rstn_d;
  logic          cnt_zero;
  logic          in_write;

`ifdef TFT_PIXEL_REPEAT_EN
  logic [TFT_PIX_CNT_W-1:0] rep_q, rep_d;
`endif

  assign cnt_zero = (cnt_q == '0);
  assign in_write = (state_q == S_WR_LOW) || (state_q == S_WR_HIGH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - cnt_t'(1);
    init_d  = init_q;
    db_d    = db_q;
    rs_d    = rs_q;
`ifdef TFT_PIXEL_REPEAT_EN
    rep_d   = rep_q;
`endif

    unique case (state_q)
      S_RST_LOW: begin
        if (cnt_zero) begin
          state_d = S_RST_WAIT;
          cnt_d   = RESET_WAIT_LD;
        end
      end
      S_RST_WAIT: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          init_d  = 1'b1;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          db_d    = in_data;
          rs_d    = ~in_is_cmd;
          state_d = S_WR_LOW;
          cnt_d   = WR_LOW_LD;
`ifdef TFT_PIXEL_REPEAT_EN
          rep_d   = (in_repeat == '0) ? TFT_PIX_CNT_W'(1) : in_repeat;
`endif
        end
      end
      S_WR_LOW: begin
        if (cnt_zero) begin
          state_d = S_WR_HIGH;
          cnt_d   = WR_HIGH_LD;
        end
      end
      S_WR_HIGH: begin
        if (cnt_zero) begin
`ifdef TFT_PIXEL_REPEAT_EN
          if (rep_q > TFT_PIX_CNT_W'(1)) begin
            rep_d   = rep_q - TFT_PIX_CNT_W'(1);
            state_d = S_WR_LOW;
            cnt_d   = WR_LOW_LD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
`else
          state_d = S_IDLE;
          cnt_d   = '0;
`endif
        end
      end
      default: begin
        state_d = S_RST_LOW;
        cnt_d   = RESET_LOW_LD;
      end
    endcase

    if (rst) begin
      state_d = S_RST_LOW;
      cnt_d   = RESET_LOW_LD;
      init_d  = 1'b0;
      db_d    = '0;
      rs_d    = 1'b0;
    end

    // Strobe/select lag the state by one clock so data is already on the bus when cs/wr fall.
    rstn_d = (state_d != S_RST_LOW);
    cs_d   = rst || !in_write;
    wr_d   = rst || (state_q != S_WR_LOW);
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    init_q  <= init_d;
    db_q    <= db_d;
    rs_q    <= rs_d;
    cs_q    <= cs_d;
    wr_q    <= wr_d;
    rstn_q  <= rstn_d;
`ifdef TFT_PIXEL_REPEAT_EN
    rep_q   <= rst ? TFT_PIX_CNT_W'(1) : rep_d;
`endif
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = in_write;
  assign init_done = init_q;
  assign tft_db    = db_q;
  assign tft_rs    = rs_q;
  assign tft_wr    = wr_q;
  assign tft_cs    = cs_q;
  assign tft_rd    = 1'b1;
  assign tft_reset = rstn_q;

endmodule

// File: tb/tb_tft_bus_writer.sv
// Bench for tft_bus_writer: timeline model of the bus plus directed literal checks.
module tb_tft_bus_writer;
  import tft_pkg::*;

  localparam int unsigned L  = 2;
  localparam int unsigned H  = 2;
  localparam int unsigned RL = 4;
  localparam int unsigned RW = 6;
  localparam int unsigned P  = L + H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_is_cmd = 1'b0;
  logic [15:0] in_data = 16'h0000;
`ifdef TFT_PIXEL_REPEAT_EN
  logic [TFT_PIX_CNT_W-1:0] in_repeat = 1;
`endif
  logic        in_ready, init_done, busy, tft_rs, tft_wr, tft_rd, tft_cs, tft_reset;
  logic [15:0] tft_db;

  always #5 clk = ~clk;

  tft_bus_writer #(
    .WR_LOW_CYC(L), .WR_HIGH_CYC(H), .RESET_LOW_CYC(RL), .RESET_WAIT_CYC(RW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_cmd(in_is_cmd), .in_data(in_data),
`ifdef TFT_PIXEL_REPEAT_EN
    .in_repeat(in_repeat),
`endif
    .init_done(init_done), .busy(busy), .tft_db(tft_db), .tft_rs(tft_rs),
    .tft_wr(tft_wr), .tft_rd(tft_rd), .tft_cs(tft_cs), .tft_reset(tft_reset)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edges since reset, edges since last accept, burst length, latched word.
  bit          m_on = 0;
  int          sr = 0;
  bit          acc = 0;
  int          sa = 0;
  int          n = 1;
  logic [15:0] m_db = 16'h0000;
  logic        m_rs = 1'b0;
  bit          rdy_before;

  function automatic bit m_init();
    return sr >= int'(RL + RW);
  endfunction
  function automatic bit m_inwr();
    return acc && (sa < n * int'(P));
  endfunction
  function automatic bit m_ready();
    return m_init() && !m_inwr();
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1; sr = 0; acc = 0; sa = 0; n = 1; m_db = 16'h0000; m_rs = 1'b0;
    end else if (m_on) begin
      rdy_before = m_ready();
      sr++;
      if (acc) sa++;
      if (rdy_before && in_valid) begin
        acc = 1; sa = 0; m_db = in_data; m_rs = ~in_is_cmd;
`ifdef TFT_PIXEL_REPEAT_EN
        n = (in_repeat == 0) ? 1 : int'(in_repeat);
`else
        n = 1;
`endif
      end
    end
  end

  bit          in_burst;
  logic        exp_wr, exp_cs;
  logic        prev_wr = 1'b1;
  int          falls = 0;
  int          cyc = 0;
  int          rise_t[$];
  logic [15:0] rise_db[$];
  logic        rise_rs[$];

  always @(negedge clk) begin
    cyc++;
    if (m_on) begin
      in_burst = acc && sa >= 1 && sa <= n * int'(P);
      exp_cs   = !in_burst;
      exp_wr   = !(in_burst && ((sa - 1) % int'(P)) < int'(L));
      check("tft_reset", tft_reset, sr >= int'(RL));
      check("init_done", init_done, m_init());
      check("in_ready",  in_ready,  m_ready());
      check("busy",      busy,      m_inwr());
      check("tft_cs",    tft_cs,    exp_cs);
      check("tft_wr",    tft_wr,    exp_wr);
      check("tft_rd",    tft_rd,    1'b1);
      check("tft_db",    tft_db,    m_db);
      check("tft_rs",    tft_rs,    m_rs);
    end
    if (prev_wr === 1'b0 && tft_wr === 1'b1) begin
      rise_t.push_back(cyc); rise_db.push_back(tft_db); rise_rs.push_back(tft_rs);
    end
    if (prev_wr === 1'b1 && tft_wr === 1'b0) falls++;
    prev_wr = tft_wr;
  end

  task automatic clear_rises();
    rise_t.delete(); rise_db.delete(); rise_rs.delete();
  endtask

  task automatic send(input logic [15:0] d, input logic cmd);
    bit got;
    got = 0;
    in_data = d; in_is_cmd = cmd; in_valid = 1'b1;
    for (int j = 0; j < 40 && !got; j++) begin
      if (in_ready === 1'b1) got = 1;
      @(negedge clk);
    end
    if (!got) check("send_timeout", 0, 1);
  endtask

  task automatic wait_init();
    bit found;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) found = 1;
    end
    if (!found) check("init_timeout", 0, 1);
  endtask

  logic [15:0] words[3] = '{16'hF800, 16'h07E0, 16'h001F};
  bit          found;

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_is_cmd = 1'b1; in_data = 16'h0022;
    repeat (3) @(negedge clk);
    check("rst_reset", tft_reset, 0);
    check("rst_cs", tft_cs, 1);
    check("rst_wr", tft_wr, 1);
    check("rst_db", tft_db, 16'h0000);
    check("rst_ready", in_ready, 0);
    check("rst_init", init_done, 0);

    // Release with in_valid already high: nothing may be accepted before init_done.
    rst = 1'b0;
    found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (i == 3) check("reset_low_last", tft_reset, 0);
      if (i == 4) check("reset_rise", tft_reset, 1);
      if (init_done === 1'b1) begin
        found = 1;
        check("init_latency", i, 10);
      end else begin
        check("preinit_ready", in_ready, 0);
      end
    end
    if (!found) check("init_timeout", 0, 1);
    check("preinit_falls", falls, 0);

    clear_rises();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("cmd_rises", rise_t.size(), 1);
    if (rise_t.size() > 0) begin
      check("cmd_db", rise_db[0], 16'h0022);
      check("cmd_rs", rise_rs[0], 0);
    end

    clear_rises();
    for (int w = 0; w < 3; w++) send(words[w], 1'b0);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b_rises", rise_t.size(), 3);
    if (rise_t.size() == 3) begin
      for (int w = 0; w < 3; w++) begin
        check("b2b_db", rise_db[w], words[w]);
        check("b2b_rs", rise_rs[w], 1);
      end
      check("b2b_gap0", rise_t[1] - rise_t[0], 5);
      check("b2b_gap1", rise_t[2] - rise_t[1], 5);
    end

    send(16'h1234, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs", tft_cs, 1);
    check("midrst_wr", tft_wr, 1);
    check("midrst_reset", tft_reset, 0);
    check("midrst_init", init_done, 0);
    rst = 1'b0;
    wait_init();

`ifdef TFT_PIXEL_REPEAT_EN
    clear_rises();
    in_repeat = 3;
    send(16'hFFFF, 1'b0);
    in_valid = 1'b0;
    repeat (16) @(negedge clk);
    check("burst3_rises", rise_t.size(), 3);
    foreach (rise_db[k]) check("burst3_db", rise_db[k], 16'hFFFF);

    clear_rises();
    in_repeat = 0;
    send(16'hABCD, 1'b1);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("burst0_rises", rise_t.size(), 1);
`endif

    for (int it = 0; it < 600; it++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 16'($urandom);
      in_is_cmd = ($urandom_range(0, 3) == 0);
`ifdef TFT_PIXEL_REPEAT_EN
      in_repeat = TFT_PIX_CNT_W'($urandom_range(0, 3));
`endif
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
